// File: rtl/bridge_sequencer.sv
// bridge_sequencer: decodes strobed 3-bit commands into an H-bridge gate
// pattern. It sequences precharge/run relays, inserts dead time between
// opposing patterns, latches faults until cleared and blinks a heartbeat LED.
module bridge_sequencer #(
  parameter int unsigned FREQ          = 50000000,
  parameter int unsigned N_ERR         = 8,
  parameter int unsigned PRECHARGE_CYC = FREQ * 15,
  parameter int unsigned HOLD_CYC      = FREQ * 1,
  parameter int unsigned DEADTIME_CYC  = 50
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_clk,
  input  logic [2:0]       cmd_bus,
  input  logic [N_ERR-1:0] err_in,
  input  logic             err_clr,
  output logic [3:0]       o_top,
  output logic [3:0]       o_bot,
  output logic             o_plus,
  output logic             o_minus,
  output logic             o_pause_p,
  output logic             o_pause_n,
  output logic             o_st,
  output logic             o_ch,
  output logic             o_fan,
  output logic             o_break,
  output logic [N_ERR-1:0] err_latch,
  output logic             cmd_idle,
  output logic             led_ready
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START1 = 3'd1,
    ST_DIS1   = 3'd2,
    ST_DIS2   = 3'd3,
    ST_DIS3   = 3'd4,
    ST_DIS4   = 3'd5,
    ST_FAULT  = 3'd6
  } cmd_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_HOLD = 2'd2
  } seq_state_t;

  // Pattern vectors carry top in [7:4] and bot in [3:0].
  // Flag vectors carry {plus, minus, pause_p, pause_n}.
  cmd_state_t       state_r, cmd_next_s, state_nxt_s;
  seq_state_t       seq_r;
  logic             cmd_clk_prev_r;
  logic             cmd_fall_s, run_ok_s, fault_s;
  logic             pat_req_s, flag_req_s, start_req_s, shut_req_s;
  logic [7:0]       pat_s, pat_r, pend_r, pend_nxt_s;
  logic [3:0]       flag_s, flag_r;
  logic             dt_active_r;
  logic [31:0]      dt_cnt_r, seq_tmr_r, hb_cnt_r, hb_lim_r;
  logic             st_r, ch_r, fan_r, brk_r, cmd_idle_r, led_r;
  logic [N_ERR-1:0] err_latch_r;

  assign cmd_fall_s = cmd_clk_prev_r & ~cmd_clk;
  assign run_ok_s   = st_r & ~ch_r & (seq_r == S_IDLE);
  assign fault_s    = |err_in;

  // Command decode: turns a falling strobe edge into FSM step and action requests.
  always_comb begin
    cmd_next_s  = state_r;
    pat_req_s   = 1'b0;
    pat_s       = 8'h00;
    flag_req_s  = 1'b0;
    flag_s      = 4'b0000;
    start_req_s = 1'b0;
    shut_req_s  = 1'b0;
    if (cmd_fall_s) begin
      case (state_r)
        ST_IDLE: begin
          case (cmd_bus)
            3'd0: begin
              pat_req_s  = 1'b1;
              flag_req_s = 1'b1;
            end
            3'd1, 3'd2, 3'd3, 3'd4: begin
              if (run_ok_s) begin
                pat_req_s  = 1'b1;
                flag_req_s = 1'b1;
                case (cmd_bus)
                  3'd1:    begin pat_s = 8'b0001_0010; flag_s = 4'b1000; end
                  3'd2:    begin pat_s = 8'b0010_0001; flag_s = 4'b0100; end
                  3'd3:    begin pat_s = 8'b0100_1000; flag_s = 4'b0010; end
                  default: begin pat_s = 8'b1000_0100; flag_s = 4'b0001; end
                endcase
              end else begin
                pat_req_s = 1'b0;
              end
            end
            3'd5: begin
              if (seq_r == S_IDLE) begin
                cmd_next_s = ST_START1;
              end else begin
                cmd_next_s = ST_IDLE;
              end
            end
            3'd6: begin
              shut_req_s = 1'b1;
              pat_req_s  = 1'b1;
              flag_req_s = 1'b1;
            end
            default: cmd_next_s = ST_DIS1;
          endcase
        end
        ST_START1: begin
          cmd_next_s = ST_IDLE;
          if (cmd_bus == 3'd0) begin
            start_req_s = 1'b1;
            pat_req_s   = 1'b1;
            flag_req_s  = 1'b1;
          end else begin
            start_req_s = 1'b0;
          end
        end
        ST_DIS1: cmd_next_s = (cmd_bus == 3'd0) ? ST_DIS2 : ST_IDLE;
        ST_DIS2: cmd_next_s = (cmd_bus == 3'd7) ? ST_DIS3 : ST_IDLE;
        ST_DIS3: cmd_next_s = (cmd_bus == 3'd0) ? ST_DIS4 : ST_IDLE;
        ST_DIS4: begin
          cmd_next_s = ST_IDLE;
          if (!st_r && !ch_r && (cmd_bus == 3'd1)) begin
            pat_req_s  = 1'b1;
            flag_req_s = 1'b1;
            pat_s      = 8'b0001_0010;
            flag_s     = 4'b1000;
          end else if (!st_r && !ch_r && (cmd_bus == 3'd3)) begin
            pat_req_s  = 1'b1;
            flag_req_s = 1'b1;
            pat_s      = 8'b0100_1000;
            flag_s     = 4'b1000;
          end else begin
            pat_req_s = 1'b0;
          end
        end
        ST_FAULT: cmd_next_s = ST_FAULT;
        default:  cmd_next_s = ST_IDLE;
      endcase
    end else begin
      cmd_next_s = state_r;
    end
  end

  // Next FSM state with fault entry and fault-clear taking precedence over commands.
  always_comb begin
    state_nxt_s = cmd_next_s;
    pend_nxt_s  = pat_req_s ? pat_s : pend_r;
    if (fault_s) begin
      state_nxt_s = ST_FAULT;
    end else if (state_r == ST_FAULT) begin
      state_nxt_s = err_clr ? ST_IDLE : ST_FAULT;
    end else begin
      state_nxt_s = cmd_next_s;
    end
  end

  // Main controller: command FSM, dead-time pattern gate, start sequencer, fault latches.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r        <= ST_IDLE;
      seq_r          <= S_IDLE;
      cmd_clk_prev_r <= 1'b0;
      pat_r          <= 8'h00;
      pend_r         <= 8'h00;
      dt_active_r    <= 1'b0;
      dt_cnt_r       <= 32'd0;
      seq_tmr_r      <= 32'd0;
      flag_r         <= 4'b0000;
      st_r           <= 1'b0;
      ch_r           <= 1'b0;
      fan_r          <= 1'b0;
      brk_r          <= 1'b0;
      cmd_idle_r     <= 1'b1;
      err_latch_r    <= {N_ERR{1'b0}};
    end else begin
      cmd_clk_prev_r <= cmd_clk;
      state_r        <= state_nxt_s;
      cmd_idle_r     <= (state_nxt_s == ST_IDLE);
      if (fault_s) begin
        pat_r       <= 8'h00;
        pend_r      <= 8'h00;
        dt_active_r <= 1'b0;
        dt_cnt_r    <= 32'd0;
        flag_r      <= 4'b0000;
        st_r        <= 1'b0;
        ch_r        <= 1'b0;
        fan_r       <= 1'b1;
        brk_r       <= 1'b1;
        seq_r       <= S_IDLE;
        seq_tmr_r   <= 32'd0;
        err_latch_r <= err_latch_r | err_in;
      end else begin
        if ((state_r == ST_FAULT) && err_clr) begin
          err_latch_r <= {N_ERR{1'b0}};
          brk_r       <= 1'b0;
        end
        // Dead time keeps its original end point; a zero pending pattern ends it early.
        if (dt_active_r) begin
          if ((pend_nxt_s == 8'h00) || (dt_cnt_r == 32'd0)) begin
            pat_r       <= pend_nxt_s;
            dt_active_r <= 1'b0;
          end else begin
            pend_r   <= pend_nxt_s;
            dt_cnt_r <= dt_cnt_r - 32'd1;
          end
        end else if (pat_req_s) begin
          if ((pat_r != 8'h00) && (pat_s != 8'h00) && (pat_s != pat_r)) begin
            pat_r       <= 8'h00;
            pend_r      <= pat_s;
            dt_active_r <= 1'b1;
            dt_cnt_r    <= DEADTIME_CYC - 32'd1;
          end else begin
            pat_r <= pat_s;
          end
        end
        if (flag_req_s) begin
          flag_r <= flag_s;
        end
        if (shut_req_s) begin
          st_r  <= 1'b0;
          ch_r  <= 1'b0;
          fan_r <= 1'b0;
          seq_r <= S_IDLE;
        end else if (start_req_s) begin
          st_r      <= 1'b0;
          ch_r      <= 1'b1;
          fan_r     <= 1'b1;
          seq_r     <= S_PRE;
          seq_tmr_r <= PRECHARGE_CYC - 32'd1;
        end else begin
          case (seq_r)
            S_PRE: begin
              if (seq_tmr_r == 32'd0) begin
                st_r      <= 1'b1;
                seq_tmr_r <= HOLD_CYC - 32'd1;
                seq_r     <= S_HOLD;
              end else begin
                seq_tmr_r <= seq_tmr_r - 32'd1;
              end
            end
            S_HOLD: begin
              if (seq_tmr_r == 32'd0) begin
                ch_r  <= 1'b0;
                seq_r <= S_IDLE;
              end else begin
                seq_tmr_r <= seq_tmr_r - 32'd1;
              end
            end
            default: seq_r <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Heartbeat: half-period counter whose length is re-chosen at each toggle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hb_cnt_r <= 32'd0;
      hb_lim_r <= FREQ;
      led_r    <= 1'b0;
    end else if (hb_cnt_r >= hb_lim_r - 32'd1) begin
      hb_cnt_r <= 32'd0;
      hb_lim_r <= (state_r == ST_FAULT) ? (FREQ / 32'd8) : FREQ;
      led_r    <= ~led_r;
    end else begin
      hb_cnt_r <= hb_cnt_r + 32'd1;
    end
  end

  assign o_top     = pat_r[7:4];
  assign o_bot     = pat_r[3:0];
  assign o_plus    = flag_r[3];
  assign o_minus   = flag_r[2];
  assign o_pause_p = flag_r[1];
  assign o_pause_n = flag_r[0];
  assign o_st      = st_r;
  assign o_ch      = ch_r;
  assign o_fan     = fan_r;
  assign o_break   = brk_r;
  assign err_latch = err_latch_r;
  assign cmd_idle  = cmd_idle_r;
  assign led_ready = led_r;

endmodule

// File: doc/bridge_sequencer.md
# bridge_sequencer

Parametrised successor to the single-bridge power-stage controller. It decodes 3-bit commands strobed on the falling edge of a filtered command clock and drives the H-bridge gate pattern, run/charge/fan relays and per-input fault latches. It adds three behaviours the earlier controller lacked: configurable timeouts, top/bottom dead-time insertion on every pattern change, and a software fault-clear path. It sits behind the input filters and in front of the pin-level output assigns.

## Interface
- `FREQ`, 50000000, system clock frequency in Hz; sets the heartbeat period.
- `N_ERR`, 8, number of fault inputs; must be ≥ 1.
- `PRECHARGE_CYC`, FREQ*15, precharge time in cycles (o_ch=1, o_st=0) before o_st asserts.
- `HOLD_CYC`, FREQ*1, cycles with o_st=1 and o_ch=1 before o_ch drops.
- `DEADTIME_CYC`, 50, cycles all gates are held low between two different non-zero patterns; must be ≥ 1.
- `clk`  in  1  system clock; the only clock.
- `rstn`  in  1  reset, synchronous and active-low.
- `cmd_clk`  in  1  filtered command strobe; the command is sampled on its falling edge.
- `cmd_bus`  in  3  filtered command code.
- `err_in`  in  N_ERR  filtered faults, active-high (inversion is done upstream).
- `err_clr`  in  1  single-cycle fault-clear request.
- `o_top`, `o_bot`  out  4 each  gate pattern; bit 0 = TOP1/BOT1.
- `o_plus`, `o_minus`, `o_pause_p`, `o_pause_n`  out  1 each  mode flags.
- `o_st`, `o_ch`, `o_fan`, `o_break`  out  1 each  run, charge, fan, break.
- `err_latch`  out  N_ERR  sticky per-input fault flags.
- `cmd_idle`  out  1  command FSM is in IDLE.
- `led_ready`  out  1  heartbeat.

## Operation
- Reset: every output 0 except `cmd_idle`=1; the registered previous `cmd_clk` is 0; all timers are 0.
- Edge detect: an edge fires in a cycle where the registered previous `cmd_clk` is 1 and the current value is 0.
- Command FSM states: IDLE, START1, DIS1, DIS2, DIS3, DIS4, FAULT. Each edge advances the FSM once. Codes below are decoded in IDLE.
- 0 PAUSE: pattern 0, all mode flags 0.
- Run codes require `run_ok` = o_st & ~o_ch & (start sequencer idle); otherwise the code is ignored.
  - 1 PLUS: top=0001, bot=0010, plus=1.
  - 2 MINUS: top=0010, bot=0001, minus=1.
  - 3 BALLAST_P: top=0100, bot=1000, pause_p=1.
  - 4 BALLAST_N: top=1000, bot=0100, pause_n=1.
  - When a run code is accepted, the mode flags not named above are 0.
- 5: go to START1 if the start sequencer is idle; otherwise stay in IDLE. In START1, code 0 starts the sequence (pattern 0, flags 0, fan=1, st=0, ch=1, start timer = PRECHARGE_CYC-1). Any code returns to IDLE.
- 6 SHUTDOWN: pattern, flags, st, ch and fan all 0; start sequencer aborted.
- 7: discharge prefix. Path IDLE -7-> DIS1 -0-> DIS2 -7-> DIS3 -0-> DIS4.
  - In DIS4, with st=0 and ch=0: code 1 gives top=0001, bot=0010, plus=1; code 3 gives top=0100, bot=1000, plus=1.
  - A wrong code at any DIS step returns to IDLE with no action.
- Start sequencer (states S_IDLE, S_PRE, S_HOLD):
  - S_PRE: when the timer reaches 0, set o_st=1, load HOLD_CYC-1, go to S_HOLD.
  - S_HOLD: when the timer reaches 0, set o_ch=0, go to S_IDLE.
- Dead time:
  - A pattern change where both the old and new patterns are non-zero and they differ drives top/bot to 0 for DEADTIME_CYC cycles, then applies the new pattern.
  - Changes to or from 0 apply immediately.
  - A new command during dead time replaces the pending pattern without restarting the counter. A pending pattern of 0 ends dead time at once.
- Fault: when any `err_in` bit is high, in the same update:
  - top/bot = 0 and pending dead time cancelled; flags = 0.
  - st=0, ch=0, fan=1, break=1; start sequencer to S_IDLE; FSM to FAULT.
  - err_latch |= err_in.
  - In FAULT, edges are ignored.
- Clear: `err_clr` high while err_in == 0 in FAULT clears err_latch and break and goes to IDLE; fan stays 1. `err_clr` is ignored while any err_in is high.
- Heartbeat: `led_ready` toggles every FREQ cycles, or every FREQ/8 cycles in FAULT. The new period loads at the next toggle.

## Timing
- Edge detected in cycle k: the FSM state, flags and immediate patterns are visible after the clock edge ending cycle k (1-cycle latency).
- Dead-time pattern: 0 from k+1 through k+DEADTIME_CYC; the new pattern appears at k+1+DEADTIME_CYC.
- Precharge: o_st rises exactly PRECHARGE_CYC cycles after o_ch rises. o_ch falls HOLD_CYC cycles after o_st rises.
- Fault in cycle j: outputs are forced at j+1. Fault has priority over a command edge and over sequencer expiry in the same cycle.
- SHUTDOWN and a sequencer expiry in the same cycle: SHUTDOWN wins.
- A `rstn`=0 sample on any cycle returns all state to reset values at the next edge, including mid dead-time and mid precharge.

## Test plan
- Start: PRECHARGE_CYC=20, HOLD_CYC=5. Send 5,0 -> ch=1, fan=1; st=1 twenty cycles later; ch=0 five cycles after that. Then send 1 -> top=0001, bot=0010, plus=1.
- Dead time: DEADTIME_CYC=4. From PLUS, send 2 -> top/bot=0 for 4 cycles, then top=0010, bot=0001, minus=1 is visible from the edge. Send 3 during the dead time -> only 0100/1000 appears, still at the original 4-cycle boundary.
- Guard: send 1 before start or during precharge -> outputs unchanged. Send 7,0,7,0,3 with st=ch=0 -> top=0100, bot=1000, plus=1. Send 7,0,6 -> no action, FSM returns to IDLE.
- Fault: pulse err_in[2] for 1 cycle while running -> next cycle all gates 0, st=ch=0, fan=break=1, err_latch=0x04. Edges are ignored afterwards. err_clr with err_in=0 -> IDLE, latch=0, break=0, fan=1.
- Clear blocked: hold err_in[0]=1 and pulse err_clr -> stays in FAULT; the heartbeat half-period is FREQ/8.
- Reset: assert rstn=0 mid dead time and mid precharge -> all outputs 0, cmd_idle=1 at the next edge.
